// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions for the countdown digit chain.
// Holds the digit type and the load-time saturation helper.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef logic [3:0] bcd_digit_t;

    function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
        bcd_digit_t r;
        if (d > 4'(BCD_MAX)) begin
            r = 4'(BCD_MAX);
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_sub.sv
// Single BCD digit decrement-with-borrow cell.
// A zero digit with borrow-in wraps to MAX and borrows from the next digit.
module bcd_sub
    import bcd_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic [3:0] din,
    input  logic       bin,
    output logic [3:0] dout,
    output logic       bout
);

    // Per-digit borrow arithmetic.
    always_comb begin
        if ((din == 4'd0) && bin) begin
            dout = 4'(MAX);
            bout = 1'b1;
        end else begin
            dout = din - {3'b000, bin};
            bout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD down-counter with reload latch, one-shot/continuous
// modes, underflow strobe and load-error strobe; all outputs registered.
module bcd_countdown
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  oneshot,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  underflow,
    output logic                  load_err
);

    localparam int W = BCD_W * DIGITS;

    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    latch_q, latch_d;
    logic            running_q, running_d;
    logic            underflow_q, underflow_d;
    logic            load_err_q, load_err_d;

    logic [W-1:0]    dec_val_s;
    logic [DIGITS:0] borrow_s;
    logic            zero_s;
    logic [W-1:0]    sat_val_s;
    logic            sat_any_s;
    logic            run_base_s;

    // Feeding tick into the chain means the top borrow-out is the zero detect.
    assign borrow_s[0] = tick;
    assign zero_s      = borrow_s[DIGITS];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_sub #(
                .MAX (BCD_MAX)
            ) u_sub (
                .din  (count_q[g*BCD_W +: BCD_W]),
                .bin  (borrow_s[g]),
                .dout (dec_val_s[g*BCD_W +: BCD_W]),
                .bout (borrow_s[g+1])
            );
        end
    endgenerate

    // Saturate each loaded nibble and flag whether any needed clamping.
    always_comb begin
        sat_val_s = '0;
        sat_any_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            sat_val_s[i*BCD_W +: BCD_W] = bcd_sat(load_val[i*BCD_W +: BCD_W]);
            if (load_val[i*BCD_W +: BCD_W] > 4'(BCD_MAX)) begin
                sat_any_s = 1'b1;
            end else begin
                sat_any_s = sat_any_s;
            end
        end
    end

    // Next-state: load beats tick; stop beats start; start re-arms after a one-shot reload.
    always_comb begin
        count_d     = count_q;
        latch_d     = latch_q;
        underflow_d = 1'b0;
        load_err_d  = 1'b0;
        run_base_s  = running_q;

        if (load) begin
            latch_d    = sat_val_s;
            count_d    = sat_val_s;
            load_err_d = sat_any_s;
        end else if (tick && running_q) begin
            if (zero_s) begin
                count_d     = latch_q;
                underflow_d = 1'b1;
                if (oneshot) begin
                    run_base_s = 1'b0;
                end else begin
                    run_base_s = running_q;
                end
            end else begin
                count_d = dec_val_s;
            end
        end else begin
            count_d = count_q;
        end

        if (stop) begin
            running_d = 1'b0;
        end else if (start) begin
            running_d = 1'b1;
        end else begin
            running_d = run_base_s;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            latch_q     <= '0;
            running_q   <= 1'b0;
            underflow_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            latch_q     <= latch_d;
            running_q   <= running_d;
            underflow_q <= underflow_d;
            load_err_q  <= load_err_d;
        end
    end

    assign count     = count_q;
    assign running   = running_q;
    assign underflow = underflow_q;
    assign load_err  = load_err_q;

endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Multi-digit BCD down-counter with a reload latch, one-shot/continuous modes and an underflow strobe. It is the decrementing counterpart of the BCD up-count digit chain used by the TOD clock. It serves any countdown function in the CIA that must expose its value in BCD, such as a TOD-style alarm countdown. Digits are chained through a per-digit borrow cell, and all outputs are registered.

## Interface
- DIGITS, default 4: number of BCD digits (1..8).
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  decrement strobe; each high cycle is one count request.
- load  in  1  captures load_val into the reload latch and the counter.
- load_val  in  4*DIGITS  packed BCD; digit 0 occupies the LSBs.
- start  in  1  sets running.
- stop  in  1  clears running.
- oneshot  in  1  selects the mode: 1 = stop at underflow, 0 = reload and continue.
- count  out  4*DIGITS  current packed BCD value.
- running  out  1  counter is armed.
- underflow  out  1  one-cycle pulse when a tick arrives while count is 0.
- load_err  out  1  one-cycle pulse when a loaded nibble was greater than 9.

## Operation
- **State:** count register, reload latch (same width), running flag, underflow flag, load_err flag.
- **Load:**
  - load=1 writes latch <= sat(load_val) and count <= sat(load_val).
  - sat() forces every nibble greater than 9 to 9. load_err pulses if any nibble was saturated.
  - load does not change running.
- **Decrement:** a tick while running and count != 0 produces count - 1 in BCD.
  - The borrow ripples from digit 0 upward.
  - A digit at 0 with borrow-in becomes 9 and borrows onward.
  - Example: 1000 -> 0999.
- **Underflow:** a tick while running and count == 0 does the following.
  - count <= latch and underflow pulses.
  - If oneshot=1, running clears in the same cycle.
  - The count sequence is N, N-1, …, 0, then reload, so the period is N+1 ticks.
  - With a latch of 0 in continuous mode, underflow pulses on every tick.
- **Idle:** ticks while running=0 are ignored, and count holds.
- **Priority within one cycle, highest first:** load, then tick.
  - If load and tick coincide, the tick is discarded and underflow does not pulse.
- **Run control:**
  - stop beats start. If both are asserted, running <= 0.
  - start while already running has no effect.
  - If oneshot underflow and start coincide, running ends up at 1 (start re-arms after reload).
- **oneshot** is sampled at the underflow cycle only. Changing it mid-count is legal.
- **Reset:** asserting rst_n mid-count aborts immediately.
  - count = 0, latch = 0, running = 0, underflow = 0, load_err = 0.
  - No pulse is generated at reset release.

## Timing
- Latency is one cycle from a sampled tick, load or start/stop to the updated count or running.
- underflow and load_err are registered. They are high for exactly the cycle in which count first shows the reloaded or loaded value.
- Back-to-back ticks are supported at full clock rate. Each high cycle counts once.
- There are no combinational paths from inputs to outputs.
- The borrow chain is combinational across DIGITS cells and must close timing at DIGITS=8.

## Structure
- **Package bcd_pkg:**
  - localparam BCD_W = 4 and BCD_MAX = 9.
  - typedef logic [3:0] bcd_digit_t.
  - function bcd_sat(bcd_digit_t) returning a saturated digit.
- **Sub-module bcd_sub:** single-digit decrement-with-borrow, the inverse of the increment digit cell.
  - Parameter MAX, default 9.
  - Ports: din, bin, dout, bout.
  - If din==0 && bin, then dout = MAX and bout = 1; otherwise dout = din - bin and bout = 0.
  - bcd_countdown instantiates DIGITS copies in a generate loop.
  - The zero-detect is the borrow-out of the top digit when tick is set.

## Test plan
- Reset, then load 0x0003 with oneshot=0, start, then 5 ticks.
  - count reads 0002, 0001, 0000, 0003, 0002.
  - underflow is high only on the 4th tick's result cycle.
- Load 0x1000, start, one tick -> count 0999, underflow 0. Then load 0x0000 and tick -> underflow pulses and count stays 0000.
- oneshot=1, load 0x0001, start, 3 ticks.
  - count reads 0000, then 0001 with underflow=1 and running=0.
  - The third tick is ignored, and count stays 0001.
- Load 0x0A5F -> count 0959, load_err pulses one cycle. Assert load and tick together at count 0000 -> the tick is discarded and there is no underflow.
- Assert start and stop together -> running=0. Assert rst_n low mid-count at 0042 while running -> all outputs 0 asynchronously, and no pulse after release.
